// File: rtl/vec_wb_merge_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : vec_wb_merge_ctrl_if
// Brief    : Request and register-file write bundle of the vector writeback
//            merge controller.
// Revision : 1.0 - initial release
// ============================================================================
interface vec_wb_merge_ctrl_if #(
    parameter int VLEN       = 512,
    parameter int ADDR_WIDTH = 5,
    parameter int MAX_VLEN   = 8 * VLEN,
    parameter int MAX_ELEM   = MAX_VLEN / 8,
    parameter int VL_WIDTH   = $clog2(MAX_ELEM) + 1
);
    // Execution-unit request
    logic                  in_valid;
    logic                  in_ready;
    logic [MAX_VLEN-1:0]   in_result;
    logic [MAX_ELEM-1:0]   in_mask;
    logic [VL_WIDTH-1:0]   in_vl;
    logic [1:0]            in_sew;
    logic [3:0]            in_lmul;
    logic [ADDR_WIDTH-1:0] in_vd;
    logic                  in_vm;
    logic                  in_vta;
    logic                  in_vma;

    // Register-file write port and old-data read-back
    logic [ADDR_WIDTH-1:0] rf_waddr;
    logic [3:0]            rf_lmul;
    logic [MAX_VLEN-1:0]   rf_wdata;
    logic                  rf_wr_en;
    logic [MAX_VLEN-1:0]   rf_dst_data;
    logic                  rf_wrong_addr;

    // Status
    logic                  busy;
    logic                  wb_done;
    logic                  wb_error;

    modport slave (
        input  in_valid, in_result, in_mask, in_vl, in_sew, in_lmul, in_vd,
               in_vm, in_vta, in_vma, rf_dst_data, rf_wrong_addr,
        output in_ready, rf_waddr, rf_lmul, rf_wdata, rf_wr_en,
               busy, wb_done, wb_error
    );

    modport master (
        output in_valid, in_result, in_mask, in_vl, in_sew, in_lmul, in_vd,
               in_vm, in_vta, in_vma, rf_dst_data, rf_wrong_addr,
        input  in_ready, rf_waddr, rf_lmul, rf_wdata, rf_wr_en,
               busy, wb_done, wb_error
    );
endinterface
`default_nettype wire

// File: rtl/vec_wb_merge_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vec_wb_merge_ctrl
// Brief    : Vector writeback controller. Merges an execution result with the
//            old destination group under mask/tail policy and issues a single
//            group write to the vector register file.
// Revision : 1.0 - initial release
// ============================================================================
module vec_wb_merge_ctrl #(
    parameter int VLEN       = 512,
    parameter int ADDR_WIDTH = 5,
    parameter int MAX_VLEN   = 8 * VLEN,
    parameter int MAX_ELEM   = MAX_VLEN / 8,
    parameter int VL_WIDTH   = $clog2(MAX_ELEM) + 1
) (
    input  logic                clk,
    input  logic                reset,
    vec_wb_merge_ctrl_if.slave  bus
);

    localparam int c_VLEN_BYTES = VLEN / 8;
    localparam int c_NUM_BYTES  = MAX_VLEN / 8;
    localparam int c_EIDX_W     = $clog2(MAX_ELEM);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MERGE = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t                r_state;
    logic                  r_in_ready;
    logic                  r_busy;
    logic                  r_wr_en;
    logic                  r_done;
    logic                  r_error;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [3:0]            r_lmul;
    logic [MAX_VLEN-1:0]   r_wdata;

    logic [MAX_VLEN-1:0]   r_result;
    logic [MAX_ELEM-1:0]   r_mask;
    logic [VL_WIDTH-1:0]   r_vl;
    logic [1:0]            r_sew;
    logic                  r_vm;
    logic                  r_vta;
    logic                  r_vma;

    logic [VL_WIDTH-1:0]   w_group_bytes;
    logic [VL_WIDTH-1:0]   w_vlmax;
    logic [VL_WIDTH-1:0]   w_vl_eff;
    logic [MAX_VLEN-1:0]   w_merged;

    // Group size in bytes; VLMAX follows because S bytes per element = 1<<sew
    always_comb begin
        w_group_bytes = VL_WIDTH'(c_VLEN_BYTES);
        case (r_lmul)
            4'b0010: w_group_bytes = VL_WIDTH'(2 * c_VLEN_BYTES);
            4'b0100: w_group_bytes = VL_WIDTH'(4 * c_VLEN_BYTES);
            4'b1000: w_group_bytes = VL_WIDTH'(8 * c_VLEN_BYTES);
            default: ;
        endcase
        w_vlmax  = w_group_bytes >> r_sew;
        w_vl_eff = (r_vl > w_vlmax) ? w_vlmax : r_vl;
    end

    // Byte-granular merge: each byte belongs to element (byte_index >> sew)
    for (genvar b = 0; b < c_NUM_BYTES; b++) begin : g_byte
        localparam logic [c_EIDX_W-1:0] c_BYTE_IDX = c_EIDX_W'(b);

        logic [c_EIDX_W-1:0] w_elem;
        logic                w_in_group;
        logic                w_body;
        logic                w_active;
        logic                w_fill_ones;

        assign w_elem      = c_BYTE_IDX >> r_sew;
        assign w_in_group  = {1'b0, c_BYTE_IDX} < w_group_bytes;
        assign w_body      = {1'b0, w_elem} < w_vl_eff;
        assign w_active    = r_vm | r_mask[w_elem];
        assign w_fill_ones = w_body ? r_vma : r_vta;

        assign w_merged[b*8 +: 8] =
            !w_in_group          ? 8'h00                      :
            (w_body && w_active) ? r_result[b*8 +: 8]         :
            w_fill_ones          ? 8'hFF                      :
                                   bus.rf_dst_data[b*8 +: 8];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_wr_en    <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_waddr    <= '0;
            r_lmul     <= 4'b0001;
            r_wdata    <= '0;
            r_result   <= '0;
            r_mask     <= '0;
            r_vl       <= '0;
            r_sew      <= 2'b00;
            r_vm       <= 1'b0;
            r_vta      <= 1'b0;
            r_vma      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid && r_in_ready) begin
                        r_result   <= bus.in_result;
                        r_mask     <= bus.in_mask;
                        r_vl       <= bus.in_vl;
                        r_sew      <= bus.in_sew;
                        r_lmul     <= bus.in_lmul;
                        r_waddr    <= bus.in_vd;
                        r_vm       <= bus.in_vm;
                        r_vta      <= bus.in_vta;
                        r_vma      <= bus.in_vma;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_MERGE;
                    end
                end
                ST_MERGE: begin
                    // Old group is on rf_dst_data this cycle; vl==0 skips the write
                    if (r_vl == '0) begin
                        r_done  <= 1'b1;
                        r_error <= 1'b0;
                        r_state <= ST_RESP;
                    end else begin
                        r_wdata <= w_merged;
                        r_wr_en <= 1'b1;
                        r_state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    // Regfile flagged the address on this cycle's negedge
                    r_wr_en <= 1'b0;
                    r_error <= bus.rf_wrong_addr;
                    r_done  <= 1'b1;
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    r_done     <= 1'b0;
                    r_error    <= 1'b0;
                    r_in_ready <= 1'b1;
                    r_busy     <= 1'b0;
                    r_state    <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready = r_in_ready;
    assign bus.busy     = r_busy;
    assign bus.rf_wr_en = r_wr_en;
    assign bus.rf_waddr = r_waddr;
    assign bus.rf_lmul  = r_lmul;
    assign bus.rf_wdata = r_wdata;
    assign bus.wb_done  = r_done;
    assign bus.wb_error = r_error;

endmodule
`default_nettype wire

// File: tb/tb_vec_wb_merge_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_vec_wb_merge_ctrl
// Brief    : Directed bench for vec_wb_merge_ctrl with a small regfile model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vec_wb_merge_ctrl;

    localparam int VLEN       = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int MAX_VLEN   = 256;
    localparam int MAX_ELEM   = 32;
    localparam int VL_WIDTH   = 6;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    vec_wb_merge_ctrl_if #(.VLEN(VLEN), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

    vec_wb_merge_ctrl #(.VLEN(VLEN), .ADDR_WIDTH(ADDR_WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Register file model: combinational group read, negedge commit
    logic [VLEN-1:0]       regs [32];
    logic                  pre_en  = 1'b0;
    int                    pre_idx = 0;
    logic [VLEN-1:0]       pre_val = '0;

    function automatic int lmul_num(input logic [3:0] l);
        case (l)
            4'b0010: return 2;
            4'b0100: return 4;
            4'b1000: return 8;
            default: return 1;
        endcase
    endfunction

    always_comb begin
        bus.rf_dst_data = '0;
        for (int k = 0; k < 8; k++) begin
            if (k < lmul_num(bus.rf_lmul) && (int'(bus.rf_waddr) + k) < 32)
                bus.rf_dst_data[k*VLEN +: VLEN] = regs[int'(bus.rf_waddr) + k];
        end
    end

    always @(negedge clk) begin
        if (!reset) bus.rf_wrong_addr <= 1'b0;
        if (pre_en) regs[pre_idx] <= pre_val;
        if (bus.rf_wr_en) begin
            if ((int'(bus.rf_waddr) % lmul_num(bus.rf_lmul)) != 0 ||
                (int'(bus.rf_waddr) + lmul_num(bus.rf_lmul)) > 32) begin
                bus.rf_wrong_addr <= 1'b1;
            end else begin
                bus.rf_wrong_addr <= 1'b0;
                for (int k = 0; k < 8; k++)
                    if (k < lmul_num(bus.rf_lmul))
                        regs[int'(bus.rf_waddr) + k] <= bus.rf_wdata[k*VLEN +: VLEN];
            end
        end
    end

    task automatic check_value(input string tag, input logic [MAX_VLEN-1:0] got,
                               input logic [MAX_VLEN-1:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int idx, input logic [VLEN-1:0] val);
        pre_en  = 1'b1;
        pre_idx = idx;
        pre_val = val;
        step();
        pre_en  = 1'b0;
    endtask

    task automatic drive_req(input logic [MAX_VLEN-1:0] res, input logic [MAX_ELEM-1:0] mask,
                             input logic [VL_WIDTH-1:0] vl, input logic [1:0] sew,
                             input logic [3:0] lmul, input logic [ADDR_WIDTH-1:0] vd,
                             input logic vm, input logic vta, input logic vma);
        bus.in_valid  = 1'b1;
        bus.in_result = res;
        bus.in_mask   = mask;
        bus.in_vl     = vl;
        bus.in_sew    = sew;
        bus.in_lmul   = lmul;
        bus.in_vd     = vd;
        bus.in_vm     = vm;
        bus.in_vta    = vta;
        bus.in_vma    = vma;
    endtask

    // Returns at the sample point of cycle 1 (first cycle after the accept edge)
    task automatic send_req(input logic [MAX_VLEN-1:0] res, input logic [MAX_ELEM-1:0] mask,
                            input logic [VL_WIDTH-1:0] vl, input logic [1:0] sew,
                            input logic [3:0] lmul, input logic [ADDR_WIDTH-1:0] vd,
                            input logic vm, input logic vta, input logic vma);
        int guard;
        guard = 0;
        drive_req(res, mask, vl, sew, lmul, vd, vm, vta, vma);
        while (!bus.in_ready && guard < 20) begin
            step();
            guard++;
        end
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic watch_resp(output int done_cyc, output logic err, output int wr_cnt,
                              output logic [MAX_VLEN-1:0] wdata);
        done_cyc = 0;
        err      = 1'b0;
        wr_cnt   = 0;
        wdata    = '0;
        for (int c = 1; c <= 6; c++) begin
            if (bus.rf_wr_en) begin
                wr_cnt++;
                wdata = bus.rf_wdata;
            end
            if (bus.wb_done && done_cyc == 0) begin
                done_cyc = c;
                err      = bus.wb_error;
            end
            step();
        end
    endtask

    int                  done_cyc;
    logic                err;
    int                  wr_cnt;
    logic [MAX_VLEN-1:0] wdata;
    logic [MAX_VLEN-1:0] big_res;
    int                  hits;

    initial begin
        drive_req('0, '0, '0, 2'b00, 4'b0001, '0, 1'b0, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_value("rst_ready_in_reset", bus.in_ready, 1);
        check_value("rst_wr_en_in_reset", bus.rf_wr_en, 0);
        reset = 1'b1;
        step();
        check_value("rst_busy", bus.busy, 0);
        check_value("rst_done_err", {bus.wb_done, bus.wb_error}, 0);
        check_value("rst_lmul", bus.rf_lmul, 4'b0001);
        check_value("rst_waddr_wdata", {bus.rf_waddr, bus.rf_wdata}, 0);

        // Masked merge: elements 0,2 from result, 1,3 old
        preload(2, 32'hAABBCCDD);
        send_req(32'h11223344, 4'b0101, 6'd4, 2'b00, 4'b0001, 5'd2, 1'b0, 1'b0, 1'b0);
        watch_resp(done_cyc, err, wr_cnt, wdata);
        check_value("mask_wdata", wdata, 256'hAA22CC44);
        check_value("mask_v2", regs[2], 32'hAABBCCDD ^ 32'hAABBCCDD ^ 32'hAA22CC44);
        check_value("mask_done_cyc", done_cyc, 3);
        check_value("mask_err", err, 0);
        check_value("mask_wr_cnt", wr_cnt, 1);

        // Tail undisturbed
        preload(2, 32'hAABBCCDD);
        send_req(32'h11223344, 4'b0000, 6'd2, 2'b00, 4'b0001, 5'd2, 1'b1, 1'b0, 1'b0);
        watch_resp(done_cyc, err, wr_cnt, wdata);
        check_value("tu_v2", regs[2], 32'hAABB3344);

        // Tail agnostic
        preload(2, 32'hAABBCCDD);
        send_req(32'h11223344, 4'b0000, 6'd2, 2'b00, 4'b0001, 5'd2, 1'b1, 1'b1, 1'b0);
        watch_resp(done_cyc, err, wr_cnt, wdata);
        check_value("ta_v2", regs[2], 32'hFFFF3344);

        // Mask agnostic
        preload(2, 32'hAABBCCDD);
        send_req(32'h11223344, 4'b0101, 6'd4, 2'b00, 4'b0001, 5'd2, 1'b0, 1'b0, 1'b1);
        watch_resp(done_cyc, err, wr_cnt, wdata);
        check_value("ma_v2", regs[2], 32'hFF22FF44);

        // SEW=16, LMUL=2 group v4/v5, vl=3, tail agnostic
        preload(4, 32'h44443333);
        preload(5, 32'h66665555);
        send_req(64'hDDDDCCCCBBBBAAAA, 4'b0000, 6'd3, 2'b01, 4'b0010, 5'd4, 1'b1, 1'b1, 1'b0);
        watch_resp(done_cyc, err, wr_cnt, wdata);
        check_value("sew16_v4", regs[4], 32'hBBBBAAAA);
        check_value("sew16_v5", regs[5], 32'hFFFFCCCC);
        check_value("sew16_err", err, 0);

        // vl above VLMAX, result upper bits set: bits above G must be 0
        preload(2, 32'hAABBCCDD);
        big_res        = '1;
        big_res[31:0]  = 32'h12345678;
        send_req(big_res, 4'b0000, 6'd5, 2'b10, 4'b0001, 5'd2, 1'b1, 1'b0, 1'b0);
        watch_resp(done_cyc, err, wr_cnt, wdata);
        check_value("clamp_wdata", wdata, 256'h12345678);
        check_value("clamp_v2", regs[2], 32'h12345678);

        // Misaligned group: regfile rejects, reported as wb_error
        preload(3, 32'h33333333);
        preload(4, 32'h44444444);
        send_req(32'h0BADF00D, 4'b0000, 6'd2, 2'b00, 4'b0010, 5'd3, 1'b1, 1'b0, 1'b0);
        watch_resp(done_cyc, err, wr_cnt, wdata);
        check_value("aerr_wr_cnt", wr_cnt, 1);
        check_value("aerr_done_cyc", done_cyc, 3);
        check_value("aerr_err", err, 1);
        check_value("aerr_v3_v4", {regs[3], regs[4]}, 64'h3333333344444444);

        // vl=0: no write, early completion, error forced clear
        preload(2, 32'hAABBCCDD);
        send_req(32'h99999999, 4'b1111, 6'd0, 2'b00, 4'b0001, 5'd2, 1'b1, 1'b1, 1'b1);
        watch_resp(done_cyc, err, wr_cnt, wdata);
        check_value("vl0_wr_cnt", wr_cnt, 0);
        check_value("vl0_done_cyc", done_cyc, 2);
        check_value("vl0_err", err, 0);
        check_value("vl0_v2", regs[2], 32'hAABBCCDD);

        // Backpressure: B held valid while A is in flight
        preload(2, 32'hAABBCCDD);
        send_req(32'h11223344, 4'b0101, 6'd4, 2'b00, 4'b0001, 5'd2, 1'b0, 1'b0, 1'b0);
        drive_req(32'h55667788, 4'b0000, 6'd4, 2'b00, 4'b0001, 5'd2, 1'b1, 1'b0, 1'b0);
        hits = 0;
        for (int c = 1; c <= 3; c++) begin
            if (bus.in_ready) hits++;
            step();
        end
        check_value("bp_ready_while_busy", hits, 0);
        check_value("bp_ready_cycle4", bus.in_ready, 1);
        check_value("bp_v2_after_a", regs[2], 32'hAA22CC44);
        step();
        bus.in_valid = 1'b0;
        watch_resp(done_cyc, err, wr_cnt, wdata);
        check_value("bp_b_done_cyc", done_cyc, 3);
        check_value("bp_b_v2", regs[2], 32'h55667788);

        // Reset during WRITE
        preload(2, 32'hAABBCCDD);
        send_req(32'h11223344, 4'b0101, 6'd4, 2'b00, 4'b0001, 5'd2, 1'b0, 1'b0, 1'b0);
        step();
        check_value("rstw_wr_en_before", bus.rf_wr_en, 1);
        reset = 1'b0;
        #1;
        check_value("rstw_wr_en_async", bus.rf_wr_en, 0);
        hits = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (bus.wb_done) hits++;
        end
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            if (bus.wb_done) hits++;
        end
        check_value("rstw_no_done", hits, 0);
        check_value("rstw_ready", bus.in_ready, 1);
        check_value("rstw_busy", bus.busy, 0);
        check_value("rstw_v2", regs[2], 32'hAABBCCDD);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
`default_nettype wire
